uart_axis_param: RTL and testbench

Parametrised full-duplex UART with an AXI4-Stream transmit input and an AXI4-Stream receive output. It replaces the fixed 8N1 UART and adds configurable data width, parity, stop bits, baud divisor, and TX/RX FIFOs. It sits between the CPU's stream fabric and the RS-232 DCE pins. It also reports framing, parity and overrun errors.

---
 rtl/uart_axis_param.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_uart_axis_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axis_param.sv
// Parametrised full-duplex UART with AXI4-Stream TX input and RX output.
// Configurable payload width, parity, stop bits and baud divisor, with a
// first-word fall-through FIFO on each direction and RX error pulses.
module uart_axis_param #(
    parameter int unsigned DIVISOR    = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rxd,
    output logic                 txd,
    input  logic [DATA_BITS-1:0] s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [DATA_BITS-1:0] m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 tx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(STOP_BITS * DIVISOR) + 1;
    localparam logic [TW-1:0] BitLoad  = TW'(DIVISOR - 1);
    localparam logic [TW-1:0] HalfLoad = TW'(DIVISOR / 2);
    localparam logic [TW-1:0] StopLoad = TW'(STOP_BITS * DIVISOR - 1);
    localparam logic [AW:0]   FullCnt  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]    LastBit  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wr_q, tx_rd_q;
    logic [AW:0]          tx_cnt_q;
    logic                 tx_push, tx_pop, tx_nonempty;
    logic [DATA_BITS-1:0] tx_head;

    assign s_tready    = (tx_cnt_q != FullCnt);
    assign tx_push     = s_tvalid & s_tready;
    assign tx_nonempty = (tx_cnt_q != '0);
    assign tx_head     = tx_mem[tx_rd_q];

    // TX FIFO storage (no reset needed, contents qualified by count)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= s_tdata;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + (AW + 1)'(1);
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - (AW + 1)'(1);
        end
    end

    // ---------------- TX FSM ----------------
    state_e               tx_state_q, tx_state_d;
    logic [TW-1:0]        tx_timer_q, tx_timer_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_load;

    assign tx_pop  = tx_load;
    assign txd     = txd_q;
    assign tx_busy = (tx_state_q != StIdle) || tx_nonempty;

    // TX next state; STOP chains straight into the next START when data waits
    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_par_d   = tx_par_q;
        tx_load    = 1'b0;
        unique case (tx_state_q)
            StIdle: tx_load = tx_nonempty;
            StStart: begin
                if (tx_timer_q == '0) begin
                    tx_state_d = StData;
                    tx_timer_d = BitLoad;
                    tx_bit_d   = '0;
                end else tx_timer_d = tx_timer_q - TW'(1);
            end
            StData: begin
                if (tx_timer_q == '0) begin
                    tx_sh_d    = tx_sh_q >> 1;
                    tx_timer_d = BitLoad;
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == LastBit) begin
                        if (PARITY != 0) tx_state_d = StParity;
                        else begin
                            tx_state_d = StStop;
                            tx_timer_d = StopLoad;
                        end
                    end
                end else tx_timer_d = tx_timer_q - TW'(1);
            end
            StParity: begin
                if (tx_timer_q == '0) begin
                    tx_state_d = StStop;
                    tx_timer_d = StopLoad;
                end else tx_timer_d = tx_timer_q - TW'(1);
            end
            StStop: begin
                if (tx_timer_q == '0) begin
                    if (tx_nonempty) tx_load = 1'b1;
                    else             tx_state_d = StIdle;
                end else tx_timer_d = tx_timer_q - TW'(1);
            end
            default: tx_state_d = StIdle;
        endcase
        if (tx_load) begin
            tx_state_d = StStart;
            tx_timer_d = BitLoad;
            tx_sh_d    = tx_head;
            tx_par_d   = (PARITY == 1) ? ~^tx_head : ^tx_head;
        end
    end

    // Line level follows the current state, registered so txd is glitch-free
    always_comb begin
        txd_d = 1'b1;
        unique case (tx_state_q)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = tx_sh_q[0];
            StParity: txd_d = tx_par_q;
            default:  txd_d = 1'b1;
        endcase
    end

    // TX state register; reset forces the line idle immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_q <= StIdle;
            tx_timer_q <= '0;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wr_q, rx_rd_q;
    logic [AW:0]          rx_cnt_q;
    logic                 rx_push, rx_pop, rx_full;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;

    assign m_tvalid = (rx_cnt_q != '0);
    assign m_tdata  = m_tvalid ? rx_mem[rx_rd_q] : '0;
    assign rx_pop   = m_tvalid & m_tready;
    assign rx_full  = (rx_cnt_q == FullCnt);

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_q] <= rx_sh_q;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
            if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + (AW + 1)'(1);
            else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - (AW + 1)'(1);
        end
    end

    // ---------------- RX FSM ----------------
    state_e        rx_state_q, rx_state_d;
    logic [TW-1:0] rx_timer_q, rx_timer_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic          rx_par_q, rx_par_d, rx_par_ok;
    logic          rx_s1_q, rxs_q, rx_prev_q;
    logic          fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;

    assign rx_frame_err  = fe_q;
    assign rx_parity_err = pe_q;
    assign rx_overrun    = ov_q;

    // Parity check over payload plus received parity bit
    always_comb begin
        rx_par_ok = 1'b1;
        if (PARITY == 1)      rx_par_ok = ^{rx_sh_q, rx_par_q};
        else if (PARITY == 2) rx_par_ok = ~^{rx_sh_q, rx_par_q};
    end

    // RX next state; only the first stop bit is sampled so it re-arms early
    always_comb begin
        rx_state_d = rx_state_q;
        rx_timer_d = rx_timer_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        rx_par_d   = rx_par_q;
        rx_push    = 1'b0;
        fe_d       = 1'b0;
        pe_d       = 1'b0;
        ov_d       = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                // Edge detect needs a prior high, so a held break never re-arms
                if (rx_prev_q && !rxs_q) begin
                    rx_state_d = StStart;
                    rx_timer_d = HalfLoad;
                end
            end
            StStart: begin
                if (rx_timer_q == '0) begin
                    if (rxs_q) rx_state_d = StIdle;
                    else begin
                        rx_state_d = StData;
                        rx_timer_d = BitLoad;
                        rx_bit_d   = '0;
                    end
                end else rx_timer_d = rx_timer_q - TW'(1);
            end
            StData: begin
                if (rx_timer_q == '0) begin
                    rx_sh_d    = {rxs_q, rx_sh_q[DATA_BITS-1:1]};
                    rx_timer_d = BitLoad;
                    rx_bit_d   = rx_bit_q + 4'd1;
                    if (rx_bit_q == LastBit) rx_state_d = (PARITY != 0) ? StParity : StStop;
                end else rx_timer_d = rx_timer_q - TW'(1);
            end
            StParity: begin
                if (rx_timer_q == '0) begin
                    rx_par_d   = rxs_q;
                    rx_state_d = StStop;
                    rx_timer_d = BitLoad;
                end else rx_timer_d = rx_timer_q - TW'(1);
            end
            StStop: begin
                if (rx_timer_q == '0) begin
                    rx_state_d = StIdle;
                    if (!rxs_q)                 fe_d = 1'b1;
                    else if (!rx_par_ok)        pe_d = 1'b1;
                    else if (rx_full && !rx_pop) ov_d = 1'b1;
                    else                        rx_push = 1'b1;
                end else rx_timer_d = rx_timer_q - TW'(1);
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // RX synchroniser, edge-detect history and state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_timer_q <= '0;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_par_q   <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            rx_s1_q    <= rxd;
            rxs_q      <= rx_s1_q;
            rx_prev_q  <= rxs_q;
            rx_state_q <= rx_state_d;
            rx_timer_q <= rx_timer_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_par_q   <= rx_par_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ov_q       <= ov_d;
        end
    end

endmodule

// File: tb/tb_uart_axis_param.sv
// Directed bench: four UART configurations (two in loopback, two driven from
// the bench) with hand-built expected waveforms and characters.
module tb_uart_axis_param;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // A: 8N1 loopback, B: 7E2 loopback, C: 8O1 driven, D: 8N1 depth 4 driven
    logic       txd_a, s_tvalid_a = 1'b0, s_tready_a, m_tvalid_a, busy_a, fe_a, pe_a, ov_a;
    logic [7:0] s_tdata_a = '0, m_tdata_a;
    logic       txd_b, s_tvalid_b = 1'b0, s_tready_b, m_tvalid_b, busy_b, fe_b, pe_b, ov_b;
    logic [6:0] s_tdata_b = '0, m_tdata_b;
    logic       txd_c, rxd_c = 1'b1, s_tready_c, m_tvalid_c, busy_c, fe_c, pe_c, ov_c;
    logic [7:0] m_tdata_c;
    logic       txd_d, rxd_d = 1'b1, s_tready_d, m_tvalid_d, busy_d, fe_d, pe_d, ov_d;
    logic       m_tready_d = 1'b0;
    logic [7:0] m_tdata_d;

    uart_axis_param #(.DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_a (.clk(clk), .resetn(resetn), .rxd(txd_a), .txd(txd_a), .s_tdata(s_tdata_a),
         .s_tvalid(s_tvalid_a), .s_tready(s_tready_a), .m_tdata(m_tdata_a),
         .m_tvalid(m_tvalid_a), .m_tready(1'b1), .tx_busy(busy_a), .rx_frame_err(fe_a),
         .rx_parity_err(pe_a), .rx_overrun(ov_a));

    uart_axis_param #(.DIVISOR(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16))
    u_b (.clk(clk), .resetn(resetn), .rxd(txd_b), .txd(txd_b), .s_tdata(s_tdata_b),
         .s_tvalid(s_tvalid_b), .s_tready(s_tready_b), .m_tdata(m_tdata_b),
         .m_tvalid(m_tvalid_b), .m_tready(1'b1), .tx_busy(busy_b), .rx_frame_err(fe_b),
         .rx_parity_err(pe_b), .rx_overrun(ov_b));

    uart_axis_param #(.DIVISOR(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_c (.clk(clk), .resetn(resetn), .rxd(rxd_c), .txd(txd_c), .s_tdata(8'h00),
         .s_tvalid(1'b0), .s_tready(s_tready_c), .m_tdata(m_tdata_c),
         .m_tvalid(m_tvalid_c), .m_tready(1'b1), .tx_busy(busy_c), .rx_frame_err(fe_c),
         .rx_parity_err(pe_c), .rx_overrun(ov_c));

    uart_axis_param #(.DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_d (.clk(clk), .resetn(resetn), .rxd(rxd_d), .txd(txd_d), .s_tdata(8'h00),
         .s_tvalid(1'b0), .s_tready(s_tready_d), .m_tdata(m_tdata_d),
         .m_tvalid(m_tvalid_d), .m_tready(m_tready_d), .tx_busy(busy_d), .rx_frame_err(fe_d),
         .rx_parity_err(pe_d), .rx_overrun(ov_d));

    // Pulse counters and received-character logs, index 0..3 = A..D
    int fe_n[4];
    int pe_n[4];
    int ov_n[4];
    logic [7:0] rxq_a[$];
    logic [7:0] rxq_b[$];
    logic [7:0] rxq_c[$];
    logic [7:0] rxq_d[$];

    always @(posedge clk) begin
        if (fe_a) fe_n[0] <= fe_n[0] + 1;
        if (pe_a) pe_n[0] <= pe_n[0] + 1;
        if (ov_a) ov_n[0] <= ov_n[0] + 1;
        if (fe_b) fe_n[1] <= fe_n[1] + 1;
        if (pe_b) pe_n[1] <= pe_n[1] + 1;
        if (ov_b) ov_n[1] <= ov_n[1] + 1;
        if (fe_c) fe_n[2] <= fe_n[2] + 1;
        if (pe_c) pe_n[2] <= pe_n[2] + 1;
        if (ov_c) ov_n[2] <= ov_n[2] + 1;
        if (fe_d) fe_n[3] <= fe_n[3] + 1;
        if (pe_d) pe_n[3] <= pe_n[3] + 1;
        if (ov_d) ov_n[3] <= ov_n[3] + 1;
        if (m_tvalid_a) rxq_a.push_back(m_tdata_a);
        if (m_tvalid_b) rxq_b.push_back({1'b0, m_tdata_b});
        if (m_tvalid_c) rxq_c.push_back(m_tdata_c);
        if (m_tvalid_d && m_tready_d) rxq_d.push_back(m_tdata_d);
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial frame, LSB (start bit) first
    function automatic logic [15:0] mk_frame(input logic [7:0] d, input logic p,
                                             input logic stp, input logic with_par);
        if (with_par) return {5'b0, stp, p, d, 1'b0};
        return {6'b0, stp, d, 1'b0};
    endfunction

    // Drive n bits of a frame onto rxd of C (sel_d=0) or D (sel_d=1), 4 cycles each
    task automatic drive_frame(input logic sel_d, input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel_d) rxd_d = f[i];
            else       rxd_c = f[i];
            repeat (4) @(negedge clk);
        end
        if (sel_d) rxd_d = 1'b1;
        else       rxd_c = 1'b1;
    endtask

    logic [7:0] chars [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic       exp_bits[$];
    logic [10:0] wave_b = 11'b11010101010;  // bit 0 sent first
    logic [7:0] drain [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       e;
    int errs, q0, f0, p0, o0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd_a), 32'd1);
        chk("rst_s_tready", 32'(s_tready_a), 32'd1);
        chk("rst_m_tvalid", 32'(m_tvalid_a), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata_a), 32'd0);
        chk("rst_tx_busy", 32'(busy_a), 32'd0);
        chk("rst_err", 32'({fe_a, pe_a, ov_a}), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 8N1 loopback, four back-to-back characters, cycle-exact waveform
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 10; j++)
                for (int c = 0; c < 4; c++)
                    exp_bits.push_back((j == 0) ? 1'b0 : (j == 9) ? 1'b1 : chars[i][j-1]);
        q0 = rxq_a.size();
        s_tdata_a = chars[0];
        s_tvalid_a = 1'b1;
        @(posedge clk);
        errs = 0;
        for (int k = 0; k < 166; k++) begin
            @(negedge clk);
            if (k < 3) s_tdata_a = chars[k+1];
            else if (k == 3) s_tvalid_a = 1'b0;
            if (k < 2) e = 1'b1;
            else if (k < 162) e = exp_bits[k-2];
            else e = 1'b1;
            if (txd_a !== e) errs++;
            if (k == 80) chk("a_busy_mid", 32'(busy_a), 32'd1);
        end
        chk("a_tx_wave", 32'(errs), 32'd0);
        repeat (10) @(negedge clk);
        chk("a_rx_count", 32'(rxq_a.size() - q0), 32'd4);
        for (int i = 0; i < 4; i++)
            if (rxq_a.size() > q0 + i) chk($sformatf("a_rx_%0d", i), 32'(rxq_a[q0+i]), 32'(chars[i]));
        chk("a_no_err", 32'(fe_n[0] + pe_n[0] + ov_n[0]), 32'd0);
        chk("a_busy_end", 32'(busy_a), 32'd0);

        // 2: 7E2 loopback of 0x55
        s_tdata_b = 7'h55;
        s_tvalid_b = 1'b1;
        @(posedge clk);
        errs = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k == 0) s_tvalid_b = 1'b0;
            if (k < 2) e = 1'b1;
            else if (k < 46) e = wave_b[(k-2)/4];
            else e = 1'b1;
            if (txd_b !== e) errs++;
        end
        chk("b_tx_wave", 32'(errs), 32'd0);
        chk("b_rx_count", 32'(rxq_b.size()), 32'd1);
        if (rxq_b.size() > 0) chk("b_rx_data", 32'(rxq_b[0]), 32'h55);
        chk("b_no_err", 32'(fe_n[1] + pe_n[1] + ov_n[1]), 32'd0);

        // 3: odd parity receiver: good char, bad parity, bad stop, glitch
        drive_frame(1'b0, mk_frame(8'h81, 1'b1, 1'b1, 1'b1), 11);
        repeat (8) @(negedge clk);
        chk("c_good_count", 32'(rxq_c.size()), 32'd1);
        if (rxq_c.size() > 0) chk("c_good_data", 32'(rxq_c[0]), 32'h81);
        p0 = pe_n[2];
        drive_frame(1'b0, mk_frame(8'h81, 1'b0, 1'b1, 1'b1), 11);
        repeat (8) @(negedge clk);
        chk("c_parity_pulse", 32'(pe_n[2] - p0), 32'd1);
        chk("c_parity_nochar", 32'(rxq_c.size()), 32'd1);
        chk("c_parity_valid", 32'(m_tvalid_c), 32'd0);
        f0 = fe_n[2];
        p0 = pe_n[2];
        drive_frame(1'b0, mk_frame(8'h5A, 1'b1, 1'b0, 1'b1), 11);
        repeat (8) @(negedge clk);
        chk("c_frame_pulse", 32'(fe_n[2] - f0), 32'd1);
        chk("c_frame_noparity", 32'(pe_n[2] - p0), 32'd0);
        chk("c_frame_nochar", 32'(rxq_c.size()), 32'd1);
        f0 = fe_n[2];
        rxd_c = 1'b0;
        repeat (2) @(negedge clk);
        rxd_c = 1'b1;
        repeat (30) @(negedge clk);
        chk("c_glitch_nopulse", 32'(fe_n[2] + pe_n[2] - f0 - p0), 32'd0);
        chk("c_glitch_nochar", 32'(rxq_c.size()), 32'd1);
        drive_frame(1'b0, mk_frame(8'h3C, 1'b1, 1'b1, 1'b1), 11);
        repeat (8) @(negedge clk);
        chk("c_recover_count", 32'(rxq_c.size()), 32'd2);
        if (rxq_c.size() > 1) chk("c_recover_data", 32'(rxq_c[1]), 32'h3C);
        chk("c_no_overrun", 32'(ov_n[2]), 32'd0);

        // 4: depth-4 RX FIFO with stalled sink, fifth character overruns
        for (int i = 0; i < 5; i++)
            drive_frame(1'b1, mk_frame(8'((i + 1) * 8'h11), 1'b0, 1'b1, 1'b0), 10);
        repeat (8) @(negedge clk);
        chk("d_overrun_pulse", 32'(ov_n[3]), 32'd1);
        chk("d_no_frame_err", 32'(fe_n[3]), 32'd0);
        chk("d_held_valid", 32'(m_tvalid_d), 32'd1);
        chk("d_held_data", 32'(m_tdata_d), 32'h11);
        m_tready_d = 1'b1;
        repeat (8) @(negedge clk);
        chk("d_drain_count", 32'(rxq_d.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (rxq_d.size() > i) chk($sformatf("d_drain_%0d", i), 32'(rxq_d[i]), 32'(drain[i]));
        chk("d_empty", 32'(m_tvalid_d), 32'd0);

        // 5: reset in the middle of a TX data bit, then a clean character
        s_tdata_a = 8'hC3;
        s_tvalid_a = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) s_tvalid_a = 1'b0;
        end
        chk("r_mid_data_low", 32'(txd_a), 32'd0);
        #1 resetn = 1'b0;
        #1 chk("r_async_txd", 32'(txd_a), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("r_s_tready", 32'(s_tready_a), 32'd1);
        chk("r_tx_busy", 32'(busy_a), 32'd0);
        chk("r_m_tvalid", 32'(m_tvalid_a), 32'd0);
        q0 = rxq_a.size();
        f0 = fe_n[0];
        s_tdata_a = 8'h96;
        s_tvalid_a = 1'b1;
        @(negedge clk);
        s_tvalid_a = 1'b0;
        repeat (55) @(negedge clk);
        chk("r_rx_count", 32'(rxq_a.size() - q0), 32'd1);
        if (rxq_a.size() > q0) chk("r_rx_data", 32'(rxq_a[q0]), 32'h96);
        chk("r_no_frame_err", 32'(fe_n[0] - f0), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
